rca_issue_ctrl: RTL and testbench
=================================

Name: rca_issue_ctrl

Overview:
- Sequential wrapper stage that sits around the 16-bit ripple-carry adder.
- Accepts operand transactions through a valid/ready handshake and registers them onto the adder's a/b/cin inputs.
- Holds those inputs stable for a programmed number of settle cycles so the gate-delayed carry chain resolves, then captures sum/cout into an output register.
- Presents the captured result downstream through a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 64, clock cycles between operand launch and result capture; legal range 1..255.
- CNT_W, 8, settle counter width; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in.
- add_a  out  WIDTH  registered operand A, driven to adder a.
- add_b  out  WIDTH  registered operand B, driven to adder b.
- add_cin  out  1  registered carry-in, driven to adder cin.
- add_sum  in  WIDTH  adder sum output.
- add_cout  in  1  adder carry-out.
- out_valid  out  1  captured result available.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  captured sum.
- out_cout  out  1  captured carry-out.
- busy  out  1  high in SETTLE or HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; add_a, add_b, add_cin, out_sum, out_cout all 0; out_valid=0; busy=0; counter=0. in_ready=1 once rst deasserts.
- States: IDLE, SETTLE, HOLD.
- in_ready rule: in_ready = (state==IDLE) | (state==HOLD & out_ready). in_ready is never high in SETTLE.
- Accept: an operand is accepted on a rising edge where in_valid & in_ready.
  - Edge loads add_a/add_b/add_cin from in_a/in_b/in_cin.
  - Counter loads SETTLE_CYCLES-1.
  - State moves to SETTLE.
- SETTLE:
  - Counter decrements each edge.
  - On the edge where counter==0: out_sum<=add_sum, out_cout<=add_cout, out_valid<=1, state -> HOLD.
  - Latency: out_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- HOLD:
  - out_valid=1 and out_sum/out_cout held stable until out_valid & out_ready.
  - On that edge with no new accept: out_valid<=0, state -> IDLE.
  - On that edge with simultaneous in_valid: new operands load, out_valid<=0, state -> SETTLE, giving back-to-back operation with no idle bubble.
- Operand stability: add_a/add_b/add_cin change only on accept edges and remain constant through all of SETTLE and HOLD.
- Output stability: out_sum/out_cout change only on capture edges. They are not cleared on handshake completion.
- in_a/in_b/in_cin are ignored whenever in_ready=0.
- Sizing: no width growth; the carry appears only on out_cout. WIDTH-bit wrap is the adder's responsibility.
- Reset mid-operation: any in-flight transaction is discarded, all outputs return to reset values immediately (asynchronous), and no out_valid pulse is produced.
- SETTLE_CYCLES=1: capture happens on the first edge after accept.

Optional Feature:
- Macro: RCA_ISSUE_SUB_EN.
- When defined:
  - Extra input in_sub (1 bit) is sampled at accept.
  - If in_sub=1: add_b <= ~in_b and add_cin <= 1, so out_sum = in_a - in_b mod 2^WIDTH and out_cout = no-borrow.
  - Extra output out_ovf is asserted with the result and holds the signed overflow of the captured operation: (add_a[MSB]==add_b[MSB]) & (out_sum[MSB]!=add_a[MSB]). It resets to 0.
- When undefined: in_sub and out_ovf do not exist, and behaviour is pure addition as above.

Decomposition:
- Shared package rca_pkg contains:
  - state typedef {IDLE, SETTLE, HOLD};
  - RCA_WIDTH=16 and RCA_SETTLE_DEFAULT=64 constants, used by the adder wrapper and this block.
- One sub-module, rca_settle_timer, holds the CNT_W down-counter:
  - inputs: load, load value;
  - output: a single done flag when the count is 0.

Test Plan (SETTLE_CYCLES=4, adder instance connected):
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release in_ready=1, out_valid=0.
- Single add: a=16'h1234, b=16'h4321, cin=0 -> out_valid rises 4 edges after accept; out_sum=16'h5555, out_cout=0; add_a/add_b stable throughout.
- Carry: a=16'hFFFF, b=16'h0001, cin=0 -> out_sum=16'h0000, out_cout=1. Also a=16'h7FFF, b=0, cin=1 -> out_sum=16'h8000, out_cout=0.
- Backpressure and back-to-back:
  - hold out_ready=0 for 10 cycles -> out_valid and out_sum stable, in_ready=0;
  - then raise out_ready with in_valid (a=1, b=2) -> same-edge accept, next out_sum=16'h0003 after 4 more edges.
- Reset mid-SETTLE: accept a=5, b=6, assert rst at edge 2 -> no out_valid ever; the next transaction a=1, b=1 yields out_sum=2.
- RCA_ISSUE_SUB_EN: a=16'h0005, b=16'h0007, sub=1 -> out_sum=16'hFFFE, out_cout=0, out_ovf=0. Also a=16'h8000, b=1, sub=1 -> out_sum=16'h7FFF, out_ovf=1.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder wrapper and its issue stage.
package rca_pkg;

    // Operand width of the gate-level ripple-carry adder.
    localparam int RCA_WIDTH          = 16;
    // Settle time that covers the worst-case carry ripple of the adder.
    localparam int RCA_SETTLE_DEFAULT = 64;

    // Issue-stage control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Two's-complement overflow: both operands share a sign and the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rca_settle_timer.sv
// Settle down-counter: loads a cycle count, decrements to zero and holds there.
// done is high whenever the count is zero.
module rca_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and saturate at zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/rca_issue_ctrl.sv
// Issue stage around the ripple-carry adder: registers operands onto the adder
// inputs, waits SETTLE_CYCLES for the carry chain to resolve, captures the
// result and hands it downstream over valid/ready.
// Optional build macro RCA_ISSUE_SUB_EN adds subtraction (in_sub) and a
// signed-overflow flag (out_ovf).
module rca_issue_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH         = RCA_WIDTH,
    parameter int SETTLE_CYCLES = RCA_SETTLE_DEFAULT,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
`ifdef RCA_ISSUE_SUB_EN
    ,
    input  logic             in_sub,
    output logic             out_ovf
`endif
);

    // Counter reload value: capture lands SETTLE_CYCLES edges after accept.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t state;
    state_t state_next;
    logic   accept;
    logic   capture;
    logic   timer_done;

    assign accept  = in_valid & in_ready;
    assign capture = (state == SETTLE) & timer_done;

    rca_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (SETTLE_LOAD),
        .done     (timer_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a HOLD handshake with a new offer goes straight to SETTLE.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETTLE;
            SETTLE:  if (timer_done) state_next = HOLD;
            HOLD:    if (out_ready) state_next = in_valid ? SETTLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state; in_ready is held low during reset.
    always_comb begin
        in_ready  = ~rst & ((state == IDLE) | ((state == HOLD) & out_ready));
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    // Operand registers: change only on accept, stable through SETTLE and HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (accept) begin
            add_a <= in_a;
`ifdef RCA_ISSUE_SUB_EN
            // Subtraction as a + ~b + 1; cout then reads as no-borrow.
            add_b   <= in_sub ? ~in_b : in_b;
            add_cin <= in_sub ? 1'b1 : in_cin;
`else
            add_b   <= in_b;
            add_cin <= in_cin;
`endif
        end
    end

    // Result registers: loaded on capture only, never cleared by the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else if (capture) begin
            out_sum  <= add_sum;
            out_cout <= add_cout;
        end
    end

`ifdef RCA_ISSUE_SUB_EN
    // Signed overflow of the captured operation, taken from the adder's own inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (capture) begin
            out_ovf <= signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_rca_issue_ctrl.sv
// Self-checking bench for rca_issue_ctrl with a behavioural adder and a
// scoreboard fed by the driver and drained by an independent monitor.
module tb_rca_issue_ctrl;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
    logic         out_ovf;

    always #5 clk = ~clk;

    // Behavioural ripple-carry adder.
    logic [W:0] add_res;
    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_sum  = add_res[W-1:0];
    assign add_cout = add_res[W];

    rca_issue_ctrl #(
        .WIDTH         (W),
        .SETTLE_CYCLES (S),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef RCA_ISSUE_SUB_EN
        ,
        .in_sub    (in_sub),
        .out_ovf   (out_ovf)
`endif
    );

`ifndef RCA_ISSUE_SUB_EN
    assign out_ovf = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W-1:0] a;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nerrors = 0;
    int   cyc = 0;
    int   last_acc_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        nchecks++;
        if (got !== want) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s, input int acc);
        exp_t e;
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = int'($signed(a));
        int   sbv = int'($signed(b));
        int   r;
        if (s) begin
            e.sum  = W'(ua - ub);
            e.cout = (ua >= ub);
            r      = sa - sbv;
        end else begin
            e.sum  = W'(ua + ub + int'(c));
            e.cout = (ua + ub + int'(c)) > 65535;
            r      = sa + sbv + int'(c);
        end
        e.ovf     = (r > 32767) || (r < -32768);
        e.a       = a;
        e.acc_cyc = acc;
        return e;
    endfunction

    // One cycle of stimulus, driven after the falling edge; records an accept.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic ordy, output logic acc);
        logic s_eff;
`ifdef RCA_ISSUE_SUB_EN
        s_eff = s;
`else
        s_eff = 1'b0;
`endif
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = c;
        in_sub    = s_eff;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            sb.push_back(model(a, b, c, s_eff, cyc + 1));
            last_acc_cyc = cyc + 1;
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        logic acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) step(1'b1, a, b, c, s, 1'b1, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, ordy, acc);
    endtask

    task automatic drain(input int limit);
        logic acc;
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        end
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic wait_valid(input int limit);
        logic acc;
        for (int i = 0; i < limit && !out_valid; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        check("wait_valid", out_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_outs"}, {add_a, add_b, add_cin, out_sum, out_cout, out_valid, busy, out_ovf}, '0);
    endtask

    // Asynchronous reset asserted mid-cycle; in-flight work is discarded.
    task automatic reset_mid(input string tag);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_outputs(tag);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check({tag, "_rel_in_ready"}, in_ready, 1);
        check({tag, "_rel_out_valid"}, out_valid, 0);
    endtask

    // Monitor: compares each new result against the scoreboard and watches stability.
    logic         was_valid = 1'b0;
    logic         was_busy = 1'b0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_cout = 1'b0;
    logic [W*2:0] prev_ops = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                was_valid = 1'b0;
                was_busy  = 1'b0;
            end else begin
                if (out_valid && !was_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_sum", out_sum, e.sum);
                        check("out_cout", out_cout, e.cout);
`ifdef RCA_ISSUE_SUB_EN
                        check("out_ovf", out_ovf, e.ovf);
`endif
                        check("latency", cyc - e.acc_cyc, S);
                        check("add_a_at_capture", add_a, e.a);
                    end
                end else if (out_valid && was_valid) begin
                    check("out_hold_stable", {out_sum, out_cout}, {prev_sum, prev_cout});
                end
                if (busy && !out_valid) check("in_ready_in_settle", in_ready, 0);
                if (busy && was_busy && cyc != last_acc_cyc)
                    check("operands_stable", {add_a, add_b, add_cin}, prev_ops);
                was_valid = out_valid;
                was_busy  = busy;
                prev_sum  = out_sum;
                prev_cout = out_cout;
                prev_ops  = {add_a, add_b, add_cin};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Power-on reset.
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_rel_in_ready", in_ready, 1);
        check("por_rel_out_valid", out_valid, 0);

        // Plain add and carry corners.
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        drain(40);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        drain(40);

        // Backpressure then same-edge back-to-back accept.
        send(16'hAAAA, 16'h1111, 1'b0, 1'b0);
        wait_valid(20);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, acc);
        check("b2b_accept", acc, 1);
        drain(40);

        // Reset while a result is held.
        send(16'h0009, 16'h0009, 1'b0, 1'b0);
        wait_valid(20);
        reset_mid("rst_hold");

        // Reset two edges into SETTLE: the transaction must vanish.
        send(16'h0005, 16'h0006, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        reset_mid("rst_settle");
        idle(10, 1'b1);
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain(40);

`ifdef RCA_ISSUE_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain(40);
`endif

        // Random traffic with random backpressure and corner operands.
        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            step($urandom_range(0, 1) == 1, ra, rb, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, acc);
        end
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
